tick_meter: RTL and testbench
=============================

# tick_meter

Receiving end of the periodic tick strobe from our delay/tick generators. Measures the mclk-cycle interval between consecutive one-cycle `tick_in` pulses, reports each interval with a valid strobe, and flags loss of the tick stream after a programmable silence. Sits beside any tick generator: as a bench monitor, or in the datapath wherever a block must confirm its strobe rate before acting on it.

## Interface
- `CNT_WDTH`, 30: width of interval counter and `period` output.
- `TIMEOUT`, 1000: max legal interval in cycles; must satisfy 1 ≤ TIMEOUT ≤ 2^CNT_WDTH−1.
- `mclk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `tick_in`  input  1  tick strobe, synchronous to mclk; normally high one cycle.
- `clr`  input  1  synchronous clear of measurement state.
- `period`  output  CNT_WDTH  last measured interval, in cycles.
- `period_valid`  output  1  one-cycle strobe: `period` just updated.
- `locked`  output  1  at least one valid interval since last IDLE entry, no timeout since.
- `timeout`  output  1  sticky: interval exceeded TIMEOUT.
- `min_period`, `max_period`  output  CNT_WDTH  present only with TICK_METER_MINMAX_EN.

## Operation
- States: IDLE (no reference tick), MEASURE (counting from last tick), TOUT (stream lost).
- Counter `cnt` runs only in MEASURE. On tick: `cnt`←1. Else: `cnt`←`cnt`+1.
- IDLE: `tick_in`=1 → MEASURE, `cnt`←1. No period reported.
- MEASURE, `tick_in`=1: `period`←`cnt`, `period_valid`←1, `locked`←1, `cnt`←1, stay.
- MEASURE, `tick_in`=0, `cnt`==TIMEOUT: → TOUT, `timeout`←1, `locked`←0. `period` holds.
- A tick arriving with `cnt`==TIMEOUT is legal: reports `period`=TIMEOUT.
- TOUT: `tick_in`=1 → MEASURE, `cnt`←1. No period reported, since the interval is invalid. `timeout` stays set.
- `tick_in` held high N cycles: each high cycle counts as a tick, giving `period`=1 repeatedly. No edge detection.
- `clr`=1: → IDLE. Clears `period`=0, `period_valid`=0, `locked`=0, `timeout`=0. `clr` overrides a same-cycle tick.
- Intervals longer than TIMEOUT never reach `period`, so no counter saturation is needed.

## Timing
- Reset (rst=0, async): state IDLE, `cnt`=0, `period`=0, `period_valid`=0, `locked`=0, `timeout`=0. With the macro, `min_period`=all ones and `max_period`=0.
- Outputs are registered. `tick_in` sampled high at edge k → `period`/`period_valid`/`locked` visible after edge k, i.e. one-cycle latency.
- `period_valid` is high exactly one cycle per reported interval.
- `timeout` rises the cycle after the edge where MEASURE sampled `cnt`==TIMEOUT with no tick, i.e. TIMEOUT+1 cycles after the last tick.
- Generator convention: a tick every FREQ_DELAY+1 cycles yields `period`=FREQ_DELAY+1.
- Reset asserted mid-measurement aborts immediately. The first tick after release only arms the meter.

## Configuration
- `TICK_METER_MINMAX_EN` defined:
  - `min_period` and `max_period` ports exist.
  - Each valid interval updates them with unsigned compare: `min_period`←min(`min_period`,new), `max_period`←max(`max_period`,new).
  - Reset and `clr` restore all ones / 0.
  - Values are visible in the same cycle as `period_valid`.
- Not defined: ports and registers are absent. All other behaviour is identical.

## Test plan
- Ticks every 4 cycles (FREQ_DELAY=3), 5 ticks → 4 `period_valid` strobes, each `period`=4. `locked`=1 after the first strobe, `timeout`=0.
- TIMEOUT=10, tick then silence → `timeout`=1 and `locked`=0 exactly 11 cycles after the tick. `period` unchanged. Next tick produces no strobe; the following tick 6 cycles later gives `period`=6.
- TIMEOUT=10, ticks exactly 10 cycles apart → `period`=10, no timeout. At 11 apart → timeout, no strobe.
- `tick_in` high 3 consecutive cycles from IDLE → 2 strobes with `period`=1. `clr` together with a tick → IDLE, all outputs zero, no strobe.
- Reset asserted mid-MEASURE → outputs zero asynchronously. After release, the first tick does not strobe.
- With TICK_METER_MINMAX_EN, intervals 5, 3, 8 → `min_period`=3, `max_period`=8. After `clr`, all ones and 0.

Source files
------------

// File: rtl/tick_meter.sv
// Measures mclk cycles between tick_in strobes; registered outputs, one-cycle latency, no backpressure.
// Optional min/max tracking of reported intervals when TICK_METER_MINMAX_EN is defined.
module tick_meter #(
   parameter int CNT_WDTH = 30,
   parameter int TIMEOUT  = 1000
) (
   input  logic                mclk,
   input  logic                rst,
   input  logic                tick_in,
   input  logic                clr,
   output logic [CNT_WDTH-1:0] period,
   output logic                period_valid,
   output logic                locked,
   output logic                timeout
`ifdef TICK_METER_MINMAX_EN
   ,
   output logic [CNT_WDTH-1:0] min_period,
   output logic [CNT_WDTH-1:0] max_period
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      TOUT    = 2'd2
   } state_t;

   localparam logic [CNT_WDTH-1:0] CNT_ONE = CNT_WDTH'(1);
   localparam logic [CNT_WDTH-1:0] CNT_MAX = CNT_WDTH'(TIMEOUT);

   state_t              state_q, state_d;
   logic [CNT_WDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WDTH-1:0] period_q, period_d;
   logic                pvld_q, pvld_d;
   logic                locked_q, locked_d;
   logic                tout_q, tout_d;
`ifdef TICK_METER_MINMAX_EN
   logic [CNT_WDTH-1:0] min_q, min_d;
   logic [CNT_WDTH-1:0] max_q, max_d;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      pvld_d   = 1'b0;
      locked_d = locked_q;
      tout_d   = tout_q;
`ifdef TICK_METER_MINMAX_EN
      min_d    = min_q;
      max_d    = max_q;
`endif
      if (clr) begin
         state_d  = IDLE;
         cnt_d    = '0;
         period_d = '0;
         locked_d = 1'b0;
         tout_d   = 1'b0;
`ifdef TICK_METER_MINMAX_EN
         min_d    = '1;
         max_d    = '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (tick_in) begin
                  state_d = MEASURE;
                  cnt_d   = CNT_ONE;
               end
            end
            MEASURE: begin
               if (tick_in) begin
                  period_d = cnt_q;
                  pvld_d   = 1'b1;
                  locked_d = 1'b1;
                  cnt_d    = CNT_ONE;
`ifdef TICK_METER_MINMAX_EN
                  if (cnt_q < min_q) min_d = cnt_q;
                  if (cnt_q > max_q) max_d = cnt_q;
`endif
               end else if (cnt_q == CNT_MAX) begin
                  // The interval is already too long; period keeps the last good value.
                  state_d  = TOUT;
                  tout_d   = 1'b1;
                  locked_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            TOUT: begin
               if (tick_in) begin
                  state_d = MEASURE;
                  cnt_d   = CNT_ONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge mclk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         period_q <= '0;
         pvld_q   <= 1'b0;
         locked_q <= 1'b0;
         tout_q   <= 1'b0;
`ifdef TICK_METER_MINMAX_EN
         min_q    <= '1;
         max_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         pvld_q   <= pvld_d;
         locked_q <= locked_d;
         tout_q   <= tout_d;
`ifdef TICK_METER_MINMAX_EN
         min_q    <= min_d;
         max_q    <= max_d;
`endif
      end
   end

   assign period       = period_q;
   assign period_valid = pvld_q;
   assign locked       = locked_q;
   assign timeout      = tout_q;
`ifdef TICK_METER_MINMAX_EN
   assign min_period   = min_q;
   assign max_period   = max_q;
`endif

endmodule

// File: tb/tb_tick_meter.sv
// Directed bench for tick_meter: expected intervals queued at stimulus time, checked by a strobe monitor.
module tb_tick_meter;
   localparam int W  = 16;
   localparam int TO = 10;

   logic         mclk = 1'b0;
   logic         rst;
   logic         tick_in;
   logic         clr;
   logic [W-1:0] period;
   logic         period_valid;
   logic         locked;
   logic         timeout;
`ifdef TICK_METER_MINMAX_EN
   logic [W-1:0] min_period;
   logic [W-1:0] max_period;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int exp_q[$];

   tick_meter #(.CNT_WDTH(W), .TIMEOUT(TO)) dut (
      .mclk         (mclk),
      .rst          (rst),
      .tick_in      (tick_in),
      .clr          (clr),
      .period       (period),
      .period_valid (period_valid),
      .locked       (locked),
      .timeout      (timeout)
`ifdef TICK_METER_MINMAX_EN
      ,
      .min_period   (min_period),
      .max_period   (max_period)
`endif
   );

   always #5 mclk = ~mclk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every strobe must match the oldest queued interval.
   always @(negedge mclk) begin
      if (rst && period_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_strobe: got period %0d, expected no strobe (t=%0t)", period, $time);
         end else begin
            check("strobe_period", int'(period), exp_q.pop_front());
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge mclk);
         #1;
      end
   endtask

   task automatic pulse();
      tick_in = 1'b1;
      step(1);
      tick_in = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step(1);
      clr = 1'b0;
   endtask

   initial begin
      rst = 1'b0; tick_in = 1'b0; clr = 1'b0;
      step(2);
      check("rst_period", int'(period), 0);
      check("rst_valid", int'(period_valid), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_timeout", int'(timeout), 0);
      rst = 1'b1;
      step(1);

      // Ticks every 4 cycles, 5 ticks -> 4 strobes of 4
      pulse();
      for (int i = 0; i < 4; i++) begin
         step(3);
         exp_q.push_back(4);
         pulse();
         if (i == 0) check("lock_after_first", int'(locked), 1);
      end
      check("steady_period", int'(period), 4);
      check("steady_timeout", int'(timeout), 0);
      do_clr();
      check("clr_locked", int'(locked), 0);
      check("clr_period", int'(period), 0);

      // Lock, then silence until timeout
      pulse();
      step(3);
      exp_q.push_back(4);
      pulse();
      step(9);
      check("pre_timeout", int'(timeout), 0);
      check("pre_timeout_locked", int'(locked), 1);
      step(1);
      check("timeout_rise", int'(timeout), 1);
      check("timeout_unlock", int'(locked), 0);
      check("timeout_period_hold", int'(period), 4);
      pulse();
      step(5);
      exp_q.push_back(6);
      pulse();
      check("rearm_period", int'(period), 6);
      check("timeout_sticky", int'(timeout), 1);
      check("relock", int'(locked), 1);
      do_clr();

      // Exactly TIMEOUT apart is legal; one more is not
      pulse();
      step(9);
      exp_q.push_back(10);
      pulse();
      check("edge_period", int'(period), 10);
      check("edge_no_timeout", int'(timeout), 0);
      step(10);
      pulse();
      check("over_timeout", int'(timeout), 1);
      check("over_period_hold", int'(period), 10);
      do_clr();

      // Held-high tick from IDLE: 3 high cycles -> 2 strobes of 1
      tick_in = 1'b1;
      exp_q.push_back(1);
      exp_q.push_back(1);
      step(3);
      tick_in = 1'b0;
      check("held_period", int'(period), 1);
      tick_in = 1'b1; clr = 1'b1;
      step(1);
      tick_in = 1'b0; clr = 1'b0;
      check("clrtick_valid", int'(period_valid), 0);
      check("clrtick_period", int'(period), 0);
      check("clrtick_locked", int'(locked), 0);
      pulse();
      check("clrtick_arm_only", int'(period_valid), 0);
      do_clr();

      // Reset mid-measurement
      pulse();
      step(3);
      exp_q.push_back(4);
      pulse();
      step(2);
      #2 rst = 1'b0;
      #1;
      check("async_rst_period", int'(period), 0);
      check("async_rst_locked", int'(locked), 0);
      @(negedge mclk);
      rst = 1'b1;
      step(1);
      pulse();
      step(4);
      exp_q.push_back(5);
      pulse();
      check("post_rst_period", int'(period), 5);

`ifdef TICK_METER_MINMAX_EN
      do_clr();
      pulse();
      step(4); exp_q.push_back(5); pulse();
      step(2); exp_q.push_back(3); pulse();
      step(7); exp_q.push_back(8); pulse();
      check("min_period", int'(min_period), 3);
      check("max_period", int'(max_period), 8);
      do_clr();
      check("clr_min", int'(min_period), (1 << W) - 1);
      check("clr_max", int'(max_period), 0);
`endif

      step(3);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
